quad_speed_error: RTL and testbench
===================================

# quad_speed_error

Measures wheel speed from a quadrature encoder over a fixed sample window. Subtracts it from a signed setpoint and presents the result as the sign-magnitude Q8.8 error word consumed by the PI speed controller. It also generates the controller's sample clock, so each controller update sees a freshly computed, stable error. One instance sits per motor, between the encoder pins and the PI block.

## Interface
Parameters:
- N_WIDTH, 17, error/speed/setpoint word width: 1 sign bit, 8 integer bits, 8 fraction bits (sign-magnitude).
- Q_WIDTH, 8, fraction bits.
- WINDOW_CYCLES, 4100, clock cycles per sample window (82 us at 50 MHz); even, ≥ 8.
- CNT_WIDTH, 16, width of the signed edge accumulator.

Ports:
- CLOCK  in  1  system clock.
- RESET  in  1  synchronous, active-high reset.
- ENC_A  in  1  encoder channel A, asynchronous.
- ENC_B  in  1  encoder channel B, asynchronous.
- SETPOINT  in  N_WIDTH  target speed, sign-magnitude Q8.8, in edges per window.
- SPEED  out  N_WIDTH  last measured speed, sign-magnitude Q8.8.
- ERROR_K  out  N_WIDTH  SETPOINT − SPEED, sign-magnitude Q8.8.
- SAMPLE_VALID  out  1  one-cycle strobe; SPEED/ERROR_K updated this cycle.
- Prescaler_clk  out  1  controller sample clock, one period per window.
- ENC_FAULT  out  1  at least one illegal encoder transition occurred in the last completed window.

## Operation
- **Input sync:** ENC_A and ENC_B each pass through a 2-FF synchronizer, then a previous-state register.
- **x4 decode:** decoding uses the Gray sequence 00→01→11→10 as forward (+1) and the reverse as −1. No change gives 0.
- **Illegal transitions:** a change on both bits in one cycle is illegal. It contributes 0 and sets the window fault flag.
- **Accumulator:** a signed two's-complement accumulator of CNT_WIDTH bits, saturating at its limits, no wrap.
- **Window counter:** counts 0..WINDOW_CYCLES−1. At the terminal count the accumulator is latched into stage 1, then reloaded with this cycle's decode contribution (0 or ±1). An edge at the terminal count belongs to the new window.
- **Stage 1:** converts the count to sign-magnitude. Magnitude saturates at 255; the value is placed in integer bits and the fraction is 0. A zero count always gives sign 0.
- **Stage 2:** samples SETPOINT. Both operands go to 18-bit two's complement; the stage subtracts and converts back.
  - Magnitude saturates at 0xFFFF (255.996).
  - A result of −0 is normalized to +0.
- **Stage 3:** registers SPEED, ERROR_K and ENC_FAULT, and pulses SAMPLE_VALID.
- **Prescaler_clk:** rises on the edge after SAMPLE_VALID. It stays high WINDOW_CYCLES/2 cycles, then low until the next rise.
- **Reset:**
  - Clears all outputs to 0, including SPEED, ERROR_K, SAMPLE_VALID, Prescaler_clk and ENC_FAULT.
  - Clears the accumulator, window counter, pipeline and synchronizers.
  - Decode is suppressed for 3 cycles after reset deasserts while the synchronizers prime.
  - Reset mid-window discards the partial count.

## Timing
- **Latency:** terminal count at edge T gives stage 1 at T, stage 2 at T+1, and outputs plus SAMPLE_VALID at T+2. Prescaler_clk rises at T+3.
- **Stability:** ERROR_K is stable for a full window around each Prescaler_clk rising edge.
- **Encoder rate:** each encoder level must be held ≥ 2 CLOCK cycles to be counted. Faster pulses are undefined.
- **First output:** the first SAMPLE_VALID arrives WINDOW_CYCLES+2 cycles after reset deasserts.
- **SETPOINT sampling:** SETPOINT is sampled only at stage 2. Changes elsewhere take effect next window.

## Structure
- **Shared package (motor-control constants):**
  - N_WIDTH and Q_WIDTH.
  - Sign-magnitude saturation constants: MAX_MAG = 17'h0FFFF, INT_MAX = 8'd255.
  - Default WINDOW_CYCLES.
- **Sub-module quad_decoder:** 2-FF synchronizers, previous state, and priming. Outputs inc, dec and illegal pulses.
- **Top:** window counter, accumulator, 3-stage pipeline and Prescaler_clk generator.

## Test plan
Bench uses WINDOW_CYCLES=100 except test 4.
1. **Reset:** assert RESET 5 cycles mid-window → all outputs 0. The next SAMPLE_VALID comes 102 cycles after deassert, with SPEED=0 and ERROR_K=SETPOINT.
2. **Forward:** 10 forward edges in a window, 4 cycles per level, SETPOINT=+12.0 (0_00001100_00000000) → SPEED=0_00001010_00000000, ERROR_K=0_00000010_00000000. Prescaler_clk rises 1 cycle after SAMPLE_VALID.
3. **Reverse:** 10 reverse edges, SETPOINT=+5.0 → SPEED=1_00001010_00000000, ERROR_K=0_00001111_00000000 (+15).
4. **Saturation:** WINDOW_CYCLES=1000, 300 reverse edges at 2 cycles/level, SETPOINT=+255.0 → SPEED=1_11111111_00000000, ERROR_K=0_11111111_11111111.
5. **Illegal and boundary:** A and B toggled in the same cycle → count unchanged, ENC_FAULT=1 for that window only. A forward edge landing exactly at terminal count → counted in the next window (next SPEED +1).
6. **Zero sign:** SETPOINT=0 with 0 edges → ERROR_K=17'h00000 (never −0). SETPOINT changed mid-window → used only at the next stage 2.

Source files
------------

// File: rtl/quad_speed_error_pkg.sv
// Shared motor-control constants and sign-magnitude Q8.8 helpers for the
// quadrature speed-error path.
package quad_speed_error_pkg;

    localparam int N_WIDTH = 17;
    localparam int Q_WIDTH = 8;
    localparam int DEFAULT_WINDOW_CYCLES = 4100;

    localparam logic [N_WIDTH-1:0] MAX_MAG = 17'h0FFFF;
    localparam logic [7:0] INT_MAX = 8'd255;

    // Cycles after reset during which the synchronizer chain is still filling.
    localparam logic [1:0] PRIME_CYCLES = 2'd3;

    typedef enum logic {
        PRE_LOW,
        PRE_HIGH
    } pre_state_t;

    // Forward successor of {A,B} in the Gray sequence 00 -> 01 -> 11 -> 10.
    function automatic logic [1:0] gray_next(input logic [1:0] s);
        case (s)
            2'b00:   return 2'b01;
            2'b01:   return 2'b11;
            2'b11:   return 2'b10;
            default: return 2'b00;
        endcase
    endfunction

    function automatic logic signed [N_WIDTH:0] sm_to_tc(input logic [N_WIDTH-1:0] sm);
        logic signed [N_WIDTH:0] mag;
        mag = {2'b00, sm[N_WIDTH-2:0]};
        return sm[N_WIDTH-1] ? -mag : mag;
    endfunction

    // Saturates the magnitude and never produces a negative zero.
    function automatic logic [N_WIDTH-1:0] tc_to_sm(input logic signed [N_WIDTH:0] v);
        logic [N_WIDTH:0]   abs_v;
        logic [N_WIDTH-2:0] mag;
        abs_v = v[N_WIDTH] ? -v : v;
        mag = (abs_v > {1'b0, MAX_MAG}) ? MAX_MAG[N_WIDTH-2:0] : abs_v[N_WIDTH-2:0];
        return {(mag != '0) && v[N_WIDTH], mag};
    endfunction

endpackage

// File: rtl/quad_speed_error_decoder.sv
// Encoder front end: 2-FF synchronizers, previous-state register and x4
// decode into single-cycle inc/dec/illegal pulses.
module quad_decoder
    import quad_speed_error_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic enc_a,
    input  logic enc_b,
    output logic inc,
    output logic dec,
    output logic illegal
);

    logic [1:0] meta;
    logic [1:0] sync;
    logic [1:0] prev;
    logic [1:0] prime_cnt;
    logic       primed;

    assign primed = (prime_cnt == PRIME_CYCLES);

    always_ff @(posedge clk) begin
        if (rst) begin
            meta      <= '0;
            sync      <= '0;
            prev      <= '0;
            prime_cnt <= '0;
        end else begin
            meta <= {enc_a, enc_b};
            sync <= meta;
            prev <= sync;
            if (!primed) begin
                prime_cnt <= prime_cnt + 2'd1;
            end
        end
    end

    // Until primed, the reset zeros in the chain would look like an edge.
    always_comb begin
        inc     = 1'b0;
        dec     = 1'b0;
        illegal = 1'b0;
        if (primed && (sync != prev)) begin
            if ((sync ^ prev) == 2'b11) begin
                illegal = 1'b1;
            end else if (sync == gray_next(prev)) begin
                inc = 1'b1;
            end else begin
                dec = 1'b1;
            end
        end
    end

endmodule

// File: rtl/quad_speed_error.sv
// Windowed encoder speed measurement, setpoint subtraction into a
// sign-magnitude Q8.8 error word, and the PI controller sample clock.
module quad_speed_error #(
    parameter int N_WIDTH       = quad_speed_error_pkg::N_WIDTH,
    parameter int Q_WIDTH       = quad_speed_error_pkg::Q_WIDTH,
    parameter int WINDOW_CYCLES = quad_speed_error_pkg::DEFAULT_WINDOW_CYCLES,
    parameter int CNT_WIDTH     = 16
) (
    input  logic               CLOCK,
    input  logic               RESET,
    input  logic               ENC_A,
    input  logic               ENC_B,
    input  logic [N_WIDTH-1:0] SETPOINT,
    output logic [N_WIDTH-1:0] SPEED,
    output logic [N_WIDTH-1:0] ERROR_K,
    output logic               SAMPLE_VALID,
    output logic               Prescaler_clk,
    output logic               ENC_FAULT
);

    import quad_speed_error_pkg::*;

    localparam int WIN_W = $clog2(WINDOW_CYCLES);
    localparam int INT_W = N_WIDTH - 1 - Q_WIDTH;
    localparam logic [WIN_W-1:0] WIN_LAST  = WIN_W'(WINDOW_CYCLES - 1);
    localparam logic [WIN_W-1:0] HALF_LAST = WIN_W'(WINDOW_CYCLES / 2 - 1);
    localparam logic signed [CNT_WIDTH-1:0] ACC_MAX = {1'b0, {(CNT_WIDTH-1){1'b1}}};
    localparam logic signed [CNT_WIDTH-1:0] ACC_MIN = {1'b1, {(CNT_WIDTH-1){1'b0}}};
    localparam logic [CNT_WIDTH:0] CNT_SAT = {{(CNT_WIDTH+1-INT_W){1'b0}}, INT_MAX};

    logic inc;
    logic dec;
    logic illegal;

    logic [WIN_W-1:0]            win_cnt;
    logic                        terminal;
    logic signed [CNT_WIDTH-1:0] acc;
    logic signed [CNT_WIDTH-1:0] acc_base;
    logic signed [CNT_WIDTH-1:0] acc_next;
    logic                        win_fault;

    logic signed [CNT_WIDTH:0]   acc_ext;
    logic [CNT_WIDTH:0]          acc_abs;
    logic [INT_W-1:0]            int_mag;

    logic               s1_valid;
    logic               s1_fault;
    logic [N_WIDTH-1:0] s1_speed;
    logic               s2_valid;
    logic               s2_fault;
    logic [N_WIDTH-1:0] s2_speed;
    logic [N_WIDTH-1:0] s2_error;

    pre_state_t       pre_state;
    pre_state_t       pre_next;
    logic [WIN_W-1:0] pre_cnt;
    logic [WIN_W-1:0] pre_cnt_next;

    quad_decoder u_decoder (
        .clk     (CLOCK),
        .rst     (RESET),
        .enc_a   (ENC_A),
        .enc_b   (ENC_B),
        .inc     (inc),
        .dec     (dec),
        .illegal (illegal)
    );

    assign terminal = (win_cnt == WIN_LAST);

    // At the terminal count the new window starts from this cycle's edge.
    always_comb begin
        acc_base = terminal ? '0 : acc;
        acc_next = acc_base;
        if (inc && (acc_base != ACC_MAX)) begin
            acc_next = acc_base + CNT_WIDTH'(1);
        end else if (dec && (acc_base != ACC_MIN)) begin
            acc_next = acc_base - CNT_WIDTH'(1);
        end
    end

    always_comb begin
        acc_ext = {acc[CNT_WIDTH-1], acc};
        acc_abs = acc_ext[CNT_WIDTH] ? -acc_ext : acc_ext;
        int_mag = (acc_abs > CNT_SAT) ? INT_MAX : acc_abs[INT_W-1:0];
    end

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            win_cnt      <= '0;
            acc          <= '0;
            win_fault    <= 1'b0;
            s1_valid     <= 1'b0;
            s1_fault     <= 1'b0;
            s1_speed     <= '0;
            s2_valid     <= 1'b0;
            s2_fault     <= 1'b0;
            s2_speed     <= '0;
            s2_error     <= '0;
            SAMPLE_VALID <= 1'b0;
            SPEED        <= '0;
            ERROR_K      <= '0;
            ENC_FAULT    <= 1'b0;
        end else begin
            win_cnt   <= terminal ? '0 : win_cnt + WIN_W'(1);
            acc       <= acc_next;
            win_fault <= terminal ? illegal : (win_fault | illegal);

            s1_valid <= terminal;
            if (terminal) begin
                s1_speed <= {acc[CNT_WIDTH-1], int_mag, {Q_WIDTH{1'b0}}};
                s1_fault <= win_fault;
            end

            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_speed <= s1_speed;
                s2_error <= tc_to_sm(sm_to_tc(SETPOINT) - sm_to_tc(s1_speed));
                s2_fault <= s1_fault;
            end

            SAMPLE_VALID <= s2_valid;
            if (s2_valid) begin
                SPEED     <= s2_speed;
                ERROR_K   <= s2_error;
                ENC_FAULT <= s2_fault;
            end
        end
    end

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            pre_state <= PRE_LOW;
            pre_cnt   <= '0;
        end else begin
            pre_state <= pre_next;
            pre_cnt   <= pre_cnt_next;
        end
    end

    always_comb begin
        pre_next     = pre_state;
        pre_cnt_next = pre_cnt;
        case (pre_state)
            PRE_LOW: begin
                if (SAMPLE_VALID) begin
                    pre_next     = PRE_HIGH;
                    pre_cnt_next = '0;
                end
            end
            PRE_HIGH: begin
                if (pre_cnt == HALF_LAST) begin
                    pre_next = PRE_LOW;
                end else begin
                    pre_cnt_next = pre_cnt + WIN_W'(1);
                end
            end
            default: pre_next = PRE_LOW;
        endcase
    end

    assign Prescaler_clk = (pre_state == PRE_HIGH);

endmodule

// File: tb/tb_quad_speed_error.sv
// Directed bench for quad_speed_error: a 100-cycle-window instance for most
// cases and a 1000-cycle-window instance for speed saturation.
module tb_quad_speed_error;

    logic        clk = 1'b0;
    logic        rst;
    logic        enc_a;
    logic        enc_b;
    logic [16:0] setpoint;
    logic [16:0] speed;
    logic [16:0] error_k;
    logic        sample_valid;
    logic        prescaler_clk;
    logic        enc_fault;

    logic        rst_s;
    logic        enc_a_s;
    logic        enc_b_s;
    logic [16:0] setpoint_s;
    logic [16:0] speed_s;
    logic [16:0] error_k_s;
    logic        sample_valid_s;
    logic        prescaler_clk_s;
    logic        enc_fault_s;

    int tests_run    = 0;
    int tests_failed = 0;
    int cyc          = 0;
    int last_valid   = 0;
    int idx          = 0;
    int idx_s        = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    quad_speed_error #(
        .N_WIDTH       (17),
        .Q_WIDTH       (8),
        .WINDOW_CYCLES (100),
        .CNT_WIDTH     (16)
    ) dut (
        .CLOCK         (clk),
        .RESET         (rst),
        .ENC_A         (enc_a),
        .ENC_B         (enc_b),
        .SETPOINT      (setpoint),
        .SPEED         (speed),
        .ERROR_K       (error_k),
        .SAMPLE_VALID  (sample_valid),
        .Prescaler_clk (prescaler_clk),
        .ENC_FAULT     (enc_fault)
    );

    quad_speed_error #(
        .N_WIDTH       (17),
        .Q_WIDTH       (8),
        .WINDOW_CYCLES (1000),
        .CNT_WIDTH     (16)
    ) dut_sat (
        .CLOCK         (clk),
        .RESET         (rst_s),
        .ENC_A         (enc_a_s),
        .ENC_B         (enc_b_s),
        .SETPOINT      (setpoint_s),
        .SPEED         (speed_s),
        .ERROR_K       (error_k_s),
        .SAMPLE_VALID  (sample_valid_s),
        .Prescaler_clk (prescaler_clk_s),
        .ENC_FAULT     (enc_fault_s)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Encoder position index 0..3 mapped to {A,B}: 00, 01, 11, 10.
    function automatic logic [1:0] gray_of(input int i);
        case (i)
            0:       return 2'b00;
            1:       return 2'b01;
            2:       return 2'b11;
            default: return 2'b10;
        endcase
    endfunction

    task automatic drive_edges(input int n, input bit forward, input int hold);
        for (int i = 0; i < n; i++) begin
            idx = forward ? (idx + 1) % 4 : (idx + 3) % 4;
            {enc_a, enc_b} = gray_of(idx);
            repeat (hold) @(negedge clk);
        end
    endtask

    task automatic wait_valid(input int budget);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!sample_valid && n < budget);
        check("sample_valid_seen", 32'(sample_valid), 32'd1);
        last_valid = cyc;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_speed"}, 32'(speed), 32'h0);
        check({tag, "_error"}, 32'(error_k), 32'h0);
        check({tag, "_valid"}, 32'(sample_valid), 32'h0);
        check({tag, "_prescaler"}, 32'(prescaler_clk), 32'h0);
        check({tag, "_fault"}, 32'(enc_fault), 32'h0);
    endtask

    initial begin
        int c0;
        int prev_valid;
        int n;

        rst        = 1'b1;
        enc_a      = 1'b0;
        enc_b      = 1'b0;
        setpoint   = 17'h00300;
        rst_s      = 1'b1;
        enc_a_s    = 1'b0;
        enc_b_s    = 1'b0;
        setpoint_s = 17'h0FF00;

        // Test 1: reset state, first-output latency, mid-window reset
        repeat (3) @(negedge clk);
        check_all_zero("por");
        rst = 1'b0;
        c0 = cyc;
        wait_valid(200);
        check("first_latency", 32'(last_valid - c0), 32'd102);
        check("first_speed", 32'(speed), 32'h0);
        check("first_error", 32'(error_k), 32'h00300);

        drive_edges(5, 1'b1, 4);
        repeat (10) @(negedge clk);
        rst = 1'b1;
        repeat (5) @(negedge clk);
        check_all_zero("midrst");
        rst = 1'b0;
        c0 = cyc;
        wait_valid(200);
        check("rst_latency", 32'(last_valid - c0), 32'd102);
        check("rst_speed", 32'(speed), 32'h0);
        check("rst_error", 32'(error_k), 32'h00300);

        // Test 2: 10 forward edges, setpoint +12.0
        setpoint = 17'h00C00;
        prev_valid = last_valid;
        drive_edges(10, 1'b1, 4);
        wait_valid(200);
        check("fwd_period", 32'(last_valid - prev_valid), 32'd100);
        check("fwd_speed", 32'(speed), 32'h00A00);
        check("fwd_error", 32'(error_k), 32'h00200);
        check("fwd_fault", 32'(enc_fault), 32'h0);
        check("presc_before", 32'(prescaler_clk), 32'h0);
        @(negedge clk);
        check("presc_rise", 32'(prescaler_clk), 32'h1);
        check("valid_pulse", 32'(sample_valid), 32'h0);
        n = 0;
        while (prescaler_clk && n < 200) begin
            n++;
            @(negedge clk);
        end
        check("presc_high_len", 32'(n), 32'd50);

        // Test 3: 10 reverse edges, setpoint +5.0
        setpoint = 17'h00500;
        drive_edges(10, 1'b0, 4);
        wait_valid(200);
        check("rev_speed", 32'(speed), 32'h10A00);
        check("rev_error", 32'(error_k), 32'h00F00);

        // Test 5a: illegal transition mixed with 3 forward edges, negative error
        setpoint = 17'h00100;
        drive_edges(3, 1'b1, 4);
        idx = (idx + 2) % 4;
        {enc_a, enc_b} = gray_of(idx);
        repeat (4) @(negedge clk);
        wait_valid(200);
        check("ill_speed", 32'(speed), 32'h00300);
        check("ill_error", 32'(error_k), 32'h10200);
        check("ill_fault", 32'(enc_fault), 32'h1);

        // Test 5b: edge landing on the terminal count belongs to the next window
        setpoint = 17'h00800;
        repeat (95) @(negedge clk);
        drive_edges(1, 1'b1, 1);
        wait_valid(200);
        check("bnd_speed_cur", 32'(speed), 32'h0);
        check("bnd_error_cur", 32'(error_k), 32'h00800);
        check("bnd_fault_clear", 32'(enc_fault), 32'h0);
        wait_valid(200);
        check("bnd_speed_next", 32'(speed), 32'h00100);
        check("bnd_error_next", 32'(error_k), 32'h00700);

        // Test 6: -0 setpoint gives +0 error; a change just after stage 2 waits a window
        setpoint = 17'h10000;
        repeat (99) @(negedge clk);
        check("hold_error", 32'(error_k), 32'h00700);
        setpoint = 17'h00700;
        @(negedge clk);
        check("late_valid", 32'(sample_valid), 32'h1);
        check("zero_speed", 32'(speed), 32'h0);
        check("zero_error", 32'(error_k), 32'h00000);
        wait_valid(200);
        check("late_sp_error", 32'(error_k), 32'h00700);

        // Test 4: 300 reverse edges in a 1000-cycle window, setpoint +255.0
        rst_s = 1'b0;
        c0 = cyc;
        repeat (5) @(negedge clk);
        for (int i = 0; i < 300; i++) begin
            idx_s = (idx_s + 3) % 4;
            {enc_a_s, enc_b_s} = gray_of(idx_s);
            repeat (2) @(negedge clk);
        end
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!sample_valid_s && n < 1000);
        check("sat_valid_seen", 32'(sample_valid_s), 32'd1);
        check("sat_latency", 32'(cyc - c0), 32'd1002);
        check("sat_speed", 32'(speed_s), 32'h1FF00);
        check("sat_error", 32'(error_k_s), 32'h0FFFF);
        check("sat_fault", 32'(enc_fault_s), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
